dec3t8_seq: RTL and testbench

Sequenced 3-to-8 decoder: the inverse of the team's 8-to-3 priority encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the matching one-hot line on an 8-bit bus, held for a programmable number of cycles.
- Sits downstream of the encoder; regenerates one-hot select/strobe lines from encoded requests.

---
 rtl/dec3t8_seq_if.sv | 34 +++
 rtl/dec3t8_seq.sv | 122 ++++++++++++
 tb/tb_dec3t8_seq.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec3t8_seq_if.sv
// Handshake and decoded-output bundle for dec3t8_seq: codes flow in on the master side,
// one-hot lines and status flow back from the decoder on the slave side.
interface dec3t8_seq_if;
  logic       en;
  logic [2:0] code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Y;
  logic       y_valid;
  logic       busy;
  logic [1:0] level;

  modport master (
    output en,
    output code,
    output in_valid,
    input  in_ready,
    input  Y,
    input  y_valid,
    input  busy,
    input  level
  );

  modport slave (
    input  en,
    input  code,
    input  in_valid,
    output in_ready,
    output Y,
    output y_valid,
    output busy,
    output level
  );
endinterface

// File: rtl/dec3t8_seq.sv
// Sequenced 3-to-8 decoder: codes are buffered in a 2-entry FIFO and each one-hot code is held
// on Y for HOLD cycles. Define DEC_ACTIVE_LOW_EN for an active-low (74x138-style) Y bus.
module dec3t8_seq #(
  parameter int unsigned HOLD = 1,
  parameter int unsigned CW   = 8
) (
  input logic         clk,
  input logic         rst,
  dec3t8_seq_if.slave bus
);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [7:0] YIdle = 8'hFF;
`else
  localparam logic [7:0] YIdle = 8'h00;
`endif

  localparam logic [CW-1:0] HoldLoad = CW'(HOLD - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    y_q, y_d;
  logic          y_valid_q, y_valid_d;

  logic [2:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] level_q;

  logic       in_ready;
  logic       push;
  logic       pop;
  logic       slot_free;
  logic [2:0] head;

  // in_ready looks only at the registered level, so a full FIFO never pushes through a pop.
  assign in_ready  = !rst && (level_q != 2'd2);
  assign push      = bus.in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign slot_free = (state_q == StIdle) || (cnt_q == '0);
  assign pop       = slot_free && (level_q != 2'd0) && bus.en;

  // FIFO storage and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.code;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 2'd1;
        2'b01:   level_q <= level_q - 2'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      y_q       <= YIdle;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StHold;
      end
      StHold: begin
        if ((cnt_q == '0) && !pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A load at the end of a hold reuses the same edge, giving back-to-back codes with no gap.
  always_comb begin
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (pop) begin
      y_d       = YIdle ^ (8'd1 << head);
      y_valid_d = 1'b1;
      cnt_d     = HoldLoad;
    end else if ((state_q == StHold) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      y_d       = YIdle;
      y_valid_d = 1'b0;
      cnt_d     = '0;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.Y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.busy     = (state_q == StHold) || (level_q != 2'd0);
  assign bus.level    = level_q;

endmodule

// File: tb/tb_dec3t8_seq.sv
// Bench for dec3t8_seq: a HOLD=1 and a HOLD=4 instance, each watched by a scoreboard that
// queues the expected Y for every accepted code and checks it is held exactly HOLD cycles.
module tb_dec3t8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [7:0] IDLE_Y = 8'hFF;
`else
  localparam logic [7:0] IDLE_Y = 8'h00;
`endif

  always #5 clk = ~clk;

  dec3t8_seq_if if1 ();
  dec3t8_seq_if if4 ();

  dec3t8_seq #(.HOLD(1), .CW(8)) u_h1 (.clk(clk), .rst(rst), .bus(if1));
  dec3t8_seq #(.HOLD(4), .CW(8)) u_h4 (.clk(clk), .rst(rst), .bus(if4));

  function automatic logic [7:0] exp_y(input logic [2:0] c);
    logic [7:0] t;
    t    = 8'h00;
    t[c] = 1'b1;
`ifdef DEC_ACTIVE_LOW_EN
    return ~t;
`else
    return t;
`endif
  endfunction

  logic [7:0]  sb1 [$];
  logic [7:0]  sb4 [$];
  int unsigned run1 = 0;
  int unsigned run4 = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb1.delete();
      run1 = 0;
    end else begin
      checks++;
      if (if1.y_valid === 1'b1) begin
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL h1_unexpected Y=%h with no code pending", if1.Y);
        end else if (if1.Y !== sb1[0]) begin
          errors++;
          $display("FAIL h1_value Y=%h required %h", if1.Y, sb1[0]);
        end else begin
          run1++;
          if (run1 == 1) begin
            void'(sb1.pop_front());
            run1 = 0;
          end
        end
      end else if (if1.Y !== IDLE_Y || run1 != 0) begin
        errors++;
        $display("FAIL h1_idle Y=%h run=%0d required Y=%h run=0", if1.Y, run1, IDLE_Y);
      end
      if (if1.in_valid === 1'b1 && if1.in_ready === 1'b1) sb1.push_back(exp_y(if1.code));
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb4.delete();
      run4 = 0;
    end else begin
      checks++;
      if (if4.y_valid === 1'b1) begin
        if (sb4.size() == 0) begin
          errors++;
          $display("FAIL h4_unexpected Y=%h with no code pending", if4.Y);
        end else if (if4.Y !== sb4[0]) begin
          errors++;
          $display("FAIL h4_value Y=%h required %h (cycle %0d of hold)", if4.Y, sb4[0], run4);
        end else begin
          run4++;
          if (run4 == 4) begin
            void'(sb4.pop_front());
            run4 = 0;
          end
        end
      end else if (if4.Y !== IDLE_Y || run4 != 0) begin
        errors++;
        $display("FAIL h4_idle Y=%h run=%0d required Y=%h run=0", if4.Y, run4, IDLE_Y);
      end
      if (if4.in_valid === 1'b1 && if4.in_ready === 1'b1) sb4.push_back(exp_y(if4.code));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Callers enter just after a rising edge; returns just after the accepting edge.
  task automatic send_h1(input logic [2:0] c);
    int n;
    n = 0;
    if1.code     = c;
    if1.in_valid = 1'b1;
    @(negedge clk);
    while (if1.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (if1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL h1_accept code %0d in_ready=%b required 1", c, if1.in_ready);
    end
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic send_h4(input logic [2:0] c);
    int n;
    n = 0;
    if4.code     = c;
    if4.in_valid = 1'b1;
    @(negedge clk);
    while (if4.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (if4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL h4_accept code %0d in_ready=%b required 1", c, if4.in_ready);
    end
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (if1.in_ready !== 1'b0 || if4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b/%b required 0/0", if1.in_ready, if4.in_ready);
    end
    checks++;
    if (if1.Y !== IDLE_Y || if4.Y !== IDLE_Y) begin
      errors++;
      $display("FAIL reset_y got %h/%h required %h", if1.Y, if4.Y, IDLE_Y);
    end
    checks++;
    if (if1.y_valid !== 1'b0 || if1.level !== 2'd0 || if1.busy !== 1'b0 ||
        if4.y_valid !== 1'b0 || if4.level !== 2'd0 || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got v=%b l=%0d b=%b / v=%b l=%0d b=%b required 0", if1.y_valid,
               if1.level, if1.busy, if4.y_valid, if4.level, if4.busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got %b/%b required 1/1", if1.in_ready, if4.in_ready);
    end
  endtask

  task automatic test_single();
    @(posedge clk);
    #1;
    send_h1(3'd3);
    @(negedge clk);
    checks++;
    if (if1.level !== 2'd1 || if1.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_queued level=%0d y_valid=%b required 1/0", if1.level, if1.y_valid);
    end
    @(negedge clk);
    checks++;
    if (if1.Y !== exp_y(3'd3) || if1.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_out Y=%h v=%b required %h/1", if1.Y, if1.y_valid, exp_y(3'd3));
    end
    @(negedge clk);
    checks++;
    if (if1.Y !== IDLE_Y || if1.y_valid !== 1'b0 || if1.level !== 2'd0 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after Y=%h v=%b l=%0d b=%b required %h/0/0/0", if1.Y, if1.y_valid,
               if1.level, if1.busy, IDLE_Y);
    end
    @(posedge clk);
    #1;
    send_h4(3'd0);
    @(negedge clk);
    checks++;
    if (if4.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL code0_early y_valid=%b required 0", if4.y_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (if4.Y !== exp_y(3'd0) || if4.y_valid !== 1'b1) begin
        errors++;
        $display("FAIL code0_hold[%0d] Y=%h v=%b required %h/1", i, if4.Y, if4.y_valid,
                 exp_y(3'd0));
      end
    end
    @(negedge clk);
    checks++;
    if (if4.Y !== IDLE_Y || if4.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL code0_end Y=%h v=%b required %h/0", if4.Y, if4.y_valid, IDLE_Y);
    end
  endtask

  task automatic test_sweep();
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_h1(3'(i));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (if1.y_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (if1.Y !== exp_y(3'(i)) || if1.y_valid !== 1'b1 || if1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep[%0d] Y=%h v=%b rdy=%b required %h/1/1", i, if1.Y, if1.y_valid,
                     if1.in_ready, exp_y(3'(i)));
          end
        end
        @(negedge clk);
        checks++;
        if (if1.y_valid !== 1'b0 || sb1.size() != 0) begin
          errors++;
          $display("FAIL sweep_end y_valid=%b pending=%0d required 0/0", if1.y_valid, sb1.size());
        end
      end
    join
  endtask

  task automatic test_backpressure();
    logic [2:0] seq [4];
    seq = '{3'd5, 3'd6, 3'd7, 3'd1};
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_h4(seq[i]);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (if4.y_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 16; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (if4.Y !== exp_y(seq[i/4]) || if4.y_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_seq[%0d] Y=%h v=%b required %h/1", i, if4.Y, if4.y_valid,
                     exp_y(seq[i/4]));
          end
          if (i == 1) begin
            checks++;
            if (if4.level !== 2'd2 || if4.in_ready !== 1'b0) begin
              errors++;
              $display("FAIL bp_full level=%0d in_ready=%b required 2/0", if4.level,
                       if4.in_ready);
            end
          end
        end
        @(negedge clk);
        checks++;
        if (if4.y_valid !== 1'b0 || if4.busy !== 1'b0 || sb4.size() != 0) begin
          errors++;
          $display("FAIL bp_end v=%b busy=%b pending=%0d required 0/0/0", if4.y_valid, if4.busy,
                   sb4.size());
        end
      end
    join
  endtask

  task automatic test_enable();
    int n;
    @(posedge clk);
    #1;
    if4.en = 1'b0;
    send_h4(3'd2);
    send_h4(3'd4);
    @(negedge clk);
    checks++;
    if (if4.level !== 2'd2 || if4.y_valid !== 1'b0 || if4.Y !== IDLE_Y || if4.busy !== 1'b1 ||
        if4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_blocked l=%0d v=%b Y=%h b=%b rdy=%b required 2/0/%h/1/0", if4.level,
               if4.y_valid, if4.Y, if4.busy, if4.in_ready, IDLE_Y);
    end
    @(posedge clk);
    #1;
    if4.en = 1'b1;
    send_h4(3'd7);
    n = 0;
    @(negedge clk);
    while (!(if4.y_valid === 1'b1 && if4.Y === exp_y(3'd4)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL en_wait_10h Y=%h required %h", if4.Y, exp_y(3'd4));
    end
    if4.en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (if4.Y !== exp_y(3'd4) || if4.y_valid !== 1'b1) begin
        errors++;
        $display("FAIL en_drop_hold[%0d] Y=%h v=%b required %h/1", i, if4.Y, if4.y_valid,
                 exp_y(3'd4));
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (if4.y_valid !== 1'b0 || if4.Y !== IDLE_Y || if4.level !== 2'd1 || if4.busy !== 1'b1) begin
        errors++;
        $display("FAIL en_held_off[%0d] v=%b Y=%h l=%0d b=%b required 0/%h/1/1", i, if4.y_valid,
                 if4.Y, if4.level, if4.busy, IDLE_Y);
      end
    end
    @(posedge clk);
    #1;
    if4.en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if4.Y !== exp_y(3'd7) || if4.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_resume Y=%h v=%b required %h/1", if4.Y, if4.y_valid, exp_y(3'd7));
    end
    n = 0;
    while (if4.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (if4.busy !== 1'b0 || sb4.size() != 0) begin
      errors++;
      $display("FAIL en_drain busy=%b pending=%0d required 0/0", if4.busy, sb4.size());
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    send_h4(3'd6);
    send_h4(3'd3);
    @(negedge clk);
    checks++;
    if (if4.Y !== exp_y(3'd6) || if4.level !== 2'd1) begin
      errors++;
      $display("FAIL rmid_setup Y=%h l=%0d required %h/1", if4.Y, if4.level, exp_y(3'd6));
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if4.Y !== IDLE_Y || if4.y_valid !== 1'b0 || if4.level !== 2'd0 || if4.busy !== 1'b0 ||
        if4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async Y=%h v=%b l=%0d b=%b rdy=%b required %h/0/0/0/0", if4.Y,
               if4.y_valid, if4.level, if4.busy, if4.in_ready, IDLE_Y);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (if4.y_valid !== 1'b0 || if4.level !== 2'd0 || if4.Y !== IDLE_Y) begin
        errors++;
        $display("FAIL rmid_quiet[%0d] v=%b l=%0d Y=%h required 0/0/%h", i, if4.y_valid,
                 if4.level, if4.Y, IDLE_Y);
      end
    end
  endtask

  initial begin
    if1.en       = 1'b1;
    if1.code     = 3'd0;
    if1.in_valid = 1'b0;
    if4.en       = 1'b1;
    if4.code     = 3'd0;
    if4.in_valid = 1'b0;
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
